fifo_ram_ctrl: RTL and testbench
================================

Name: fifo_ram_ctrl

Overview:
- First-word-fall-through FIFO controller that sits directly upstream and downstream of the dual-port RAM.
- Drives the RAM write side (ram_waddr, ram_din, ram_write_en) and read address (ram_raddr).
- Consumes the RAM's registered read data, which has 1-cycle latency.
- A 2-entry prefetch buffer hides that latency so pop_data is valid whenever empty is low, giving full 1-word/cycle throughput.
- Used for UART/debug-port staging and instruction-fetch queues in the MCU.

Parameters:
ADDR_WIDTH, 5, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 32, word width

Ports:
clk  input  1  single clock
reset_n  input  1  asynchronous active-low reset
sync_reset  input  1  synchronous flush, active-high
push  input  1  write request
push_data  input  DATA_WIDTH  write word
full  output  1  high when RAM section holds DEPTH words; push is ignored
pop  input  1  read request, honoured only when empty=0
pop_data  output  DATA_WIDTH  head word, valid when empty=0
empty  output  1  no word available at head
count  output  ADDR_WIDTH+2  total words held (RAM + in-flight + buffer), max DEPTH+2
ram_waddr  output  ADDR_WIDTH  to RAM waddr
ram_raddr  output  ADDR_WIDTH  to RAM raddr
ram_din  output  DATA_WIDTH  to RAM din
ram_write_en  output  1  to RAM write_en
ram_dout  input  DATA_WIDTH  from RAM dout, registered, 1-cycle latency

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, reset_n. All state resets on reset_n low. Reset values:
  - wr_ptr, rd_ptr = 0 (each ADDR_WIDTH+1 bits, MSB is the wrap bit)
  - rd_pending = 0, buf_cnt = 0
  - full = 0, empty = 1, count = 0, ram_write_en = 0, pop_data = 0
- Pointers and RAM occupancy:
  - ram_cnt = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
  - full = (ram_cnt == DEPTH), registered-pointer based.
- Write path:
  - push_acc = push & ~full.
  - ram_write_en = push_acc, combinational.
  - ram_waddr = wr_ptr[ADDR_WIDTH-1:0], ram_din = push_data.
  - wr_ptr increments on push_acc.
- Read issue:
  - pop_acc = pop & ~empty.
  - rd_issue = (ram_cnt != 0) & ((buf_cnt + rd_pending - pop_acc) < 2).
  - ram_raddr = rd_ptr[ADDR_WIDTH-1:0] at all times. rd_ptr increments on rd_issue; rd_pending <= rd_issue.
  - ram_cnt uses registered wr_ptr, so a slot written this cycle is never read this cycle. No read-during-write hazard.
- Prefetch buffer (2 entries, b0 = head, b1 = next):
  - When rd_pending = 1, ram_dout is captured the same edge into the first free slot after pop_acc shifts b1 to b0.
  - Simultaneous pop and capture with buf_cnt = 1: the captured word goes to b0.
- Outputs:
  - pop_data = b0; empty = (buf_cnt == 0).
  - count = ram_cnt + rd_pending + buf_cnt.
- Latency: push into an empty FIFO at cycle N -> rd_issue at N+1 -> captured at end of N+2 -> empty=0 at N+3.
- Throughput: sustained push and pop, 1 word/cycle, no bubbles.
- Boundaries:
  - Push while full: dropped, no pointer change.
  - Pop while empty: ignored.
  - Push and pop in the same cycle: both are honoured independently.
  - Wrap: pointer MSB toggles at DEPTH; full and empty stay correct across the wrap.
  - sync_reset: same effect as reset on the next edge. The in-flight read is discarded and push/pop that cycle are ignored.
  - reset_n mid-burst: immediate return to reset values. RAM contents are don't-care.

Optional Feature:
- Macro FIFO_RAM_CTRL_ERR_FLAG_EN.
- When defined, adds two output ports, both 1 bit:
  - overflow: sticky, set on push & full.
  - underflow: sticky, set on pop & empty.
  - Both cleared by reset_n or sync_reset.
- When undefined, the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- Package fifo_ram_pkg holds:
  - localparam function for DEPTH
  - typedef for the pointer, logic [ADDR_WIDTH:0]
  - buf_cnt type, logic [1:0]
- One natural sub-module, fifo_prefetch_buf: the 2-entry buffer with the capture/shift logic. Top level keeps the pointers and the read-issue logic.
- The RAM is instantiated beside this block by the integrator, not inside it.

Test Plan:
- Reset/idle: hold reset_n=0 with random push/pop -> empty=1, full=0, count=0, ram_write_en=0. Release with no activity -> outputs unchanged.
- Latency: push 0xA5A5_0001 at cycle N into an empty FIFO -> empty=0 at N+3, pop_data=0xA5A5_0001, count=1.
- Fill/full: push 40 words 0..39 with no pops (ADDR_WIDTH=5):
  - words 0..33 accepted (RAM 32 + buffer 2);
  - full=1 once ram_cnt=32, count=34;
  - words 34..39 dropped; with FIFO_RAM_CTRL_ERR_FLAG_EN, overflow=1.
  - Drain -> sequence 0..33 in order.
- Streaming and wrap: push and pop every cycle for 100 words after a 3-cycle prime -> in-order data, empty never reasserts, pointers wrap at least 3 times.
- Random push/pop for 10k cycles against a queue model -> data order matches, and count always equals the model's size.
- Flush: sync_reset pulse with count=10 and rd_pending=1 -> next cycle empty=1, count=0. A subsequent push of 0x1234 pops as 0x1234, with no stale data.

Source files
------------

// File: rtl/fifo_ram_ctrl_pkg.sv
// Shared types and helpers for the FWFT FIFO controller that fronts an external dual-port RAM.
// Optional error flags are enabled with the FIFO_RAM_CTRL_ERR_FLAG_EN macro in the top level.
package fifo_ram_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;
    typedef logic [1:0]              buf_cnt_t;

endpackage

// File: rtl/fifo_ram_ctrl_if.sv
// RAM-side bus between the FIFO controller (master) and the external dual-port RAM (slave).
// The RAM returns registered read data one cycle after ram_raddr is presented.
interface fifo_ram_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_write_en;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport master (
        output ram_waddr,
        output ram_raddr,
        output ram_din,
        output ram_write_en,
        input  ram_dout
    );

    modport slave (
        input  ram_waddr,
        input  ram_raddr,
        input  ram_din,
        input  ram_write_en,
        output ram_dout
    );
endinterface

// File: rtl/fifo_ram_ctrl_prefetch_buf.sv
// Two-entry prefetch buffer: b0 is the FIFO head, b1 the next word.
// A pop shifts b1 into b0 before the incoming RAM word lands in the first free slot.
module fifo_prefetch_buf
    import fifo_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  pop_acc,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output buf_cnt_t              buf_cnt
);

    logic [DATA_WIDTH-1:0] b0, b1, b0_next, b1_next;
    buf_cnt_t              cnt_after_pop, cnt_next;

    always_comb begin
        cnt_after_pop = buf_cnt - {1'b0, pop_acc};
        b0_next       = pop_acc ? b1 : b0;
        b1_next       = b1;
        cnt_next      = cnt_after_pop;
        if (capture) begin
            if (cnt_after_pop == 2'd0) begin
                b0_next = din;
            end else begin
                b1_next = din;
            end
            cnt_next = cnt_after_pop + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b0      <= '0;
            b1      <= '0;
            buf_cnt <= '0;
        end else if (sync_reset) begin
            b0      <= '0;
            b1      <= '0;
            buf_cnt <= '0;
        end else begin
            b0      <= b0_next;
            b1      <= b1_next;
            buf_cnt <= cnt_next;
        end
    end

    assign head = b0;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// First-word-fall-through FIFO controller driving an external 1-cycle-latency dual-port RAM.
// Define FIFO_RAM_CTRL_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module fifo_ram_ctrl
    import fifo_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] count,
    fifo_ram_if.master            ram
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, ram_cnt;
    logic                rd_pending;
    buf_cnt_t            buf_cnt;
    logic                push_acc, pop_acc, rd_issue;
    logic [2:0]          demand;

    assign ram_cnt = wr_ptr - rd_ptr;
    assign full    = (ram_cnt == (ADDR_WIDTH+1)'(DEPTH));
    assign empty   = (buf_cnt == 2'd0);

    // A flushing or resetting cycle must not touch the RAM or the pointers.
    assign push_acc = push & ~full & ~sync_reset & reset_n;
    assign pop_acc  = pop & ~empty & ~sync_reset;

    // Words already owed to the buffer after this cycle's pop; keep at most two.
    assign demand   = {1'b0, buf_cnt} + {2'b00, rd_pending} - {2'b00, pop_acc};
    assign rd_issue = (ram_cnt != '0) & (demand < 3'd2) & ~sync_reset;

    assign ram.ram_write_en = push_acc;
    assign ram.ram_waddr    = wr_ptr[ADDR_WIDTH-1:0];
    assign ram.ram_din      = push_data;
    assign ram.ram_raddr    = rd_ptr[ADDR_WIDTH-1:0];

    assign count = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(rd_pending)
                 + (ADDR_WIDTH+2)'(buf_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
        end else if (sync_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_pending <= rd_issue;
        end
    end

    fifo_prefetch_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_prefetch_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .pop_acc   (pop_acc),
        .capture   (rd_pending),
        .din       (ram.ram_dout),
        .head      (pop_data),
        .buf_cnt   (buf_cnt)
    );

`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sync_reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (push & full);
            underflow <= underflow | (pop & empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl with a behavioural 1-cycle-latency RAM and a queue scoreboard.
// Build with FIFO_RAM_CTRL_ERR_FLAG_EN defined to also check the sticky error flags.
module tb_fifo_ram_ctrl;
    import fifo_ram_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          sync_reset;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;
    logic          full;
    logic [DW-1:0] pop_data;
    logic          empty;
    logic [AW+1:0] count;
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
    logic          overflow;
    logic          underflow;
`endif

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] mem[DEPTH];

    fifo_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram_bus ();

    fifo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sync_reset(sync_reset),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .count     (count),
        .ram       (ram_bus.master)
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_bus.ram_write_en) mem[ram_bus.ram_waddr] <= ram_bus.ram_din;
        ram_bus.ram_dout <= mem[ram_bus.ram_raddr];
    end

    typedef struct {
        logic          push;
        logic [DW-1:0] data;
        logic          pop;
        logic          exp_empty;
        logic [AW+1:0] exp_count;
        logic          chk_data;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock cycle of stimulus; an honoured pop is compared against the scoreboard head.
    task automatic applyStimulus(input logic p, input logic [DW-1:0] d, input logic q, input logic accept);
        push      = p;
        push_data = d;
        pop       = q;
        if (q && !empty) begin
            if (sb.size() == 0) begin
                checkOutput("pop_with_empty_model", 64'd1, 64'd0);
            end else begin
                checkOutput("pop_data", 64'(pop_data), 64'(sb[0]));
                void'(sb.pop_front());
            end
        end
        if (p && accept) sb.push_back(d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic drainAll(input string name);
        for (int k = 0; k < 200 && sb.size() > 0; k++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput({name, "_left"}, 64'(sb.size()), 64'd0);
        checkOutput({name, "_empty"}, 64'(empty), 64'd1);
        checkOutput({name, "_count"}, 64'(count), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 7'd1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 7'd1, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 7'd1, 1'b1, 32'hA5A5_0001};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 7'd0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 32'h11,        1'b1, 1'b1, 7'd1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h22,        1'b0, 1'b1, 7'd2, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b0, 7'd2, 1'b1, 32'h11};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 7'd1, 1'b1, 32'h22};
        vecs[8]  = '{1'b1, 32'h33,        1'b1, 1'b1, 7'd1, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 7'd1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b0, 7'd1, 1'b1, 32'h33};
        vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 7'd0, 1'b0, 32'h0};

        reset_n    = 1'b0;
        sync_reset = 1'b0;
        push       = 1'b0;
        push_data  = '0;
        pop        = 1'b0;

        // Reset held with random activity: nothing may leak through.
        for (int i = 0; i < 5; i++) begin
            push      = 1'($urandom_range(0, 1));
            pop       = 1'($urandom_range(0, 1));
            push_data = $urandom;
            @(posedge clk);
            #1;
            checkOutput("rst_empty", 64'(empty), 64'd1);
            checkOutput("rst_full", 64'(full), 64'd0);
            checkOutput("rst_count", 64'(count), 64'd0);
            checkOutput("rst_write_en", 64'(ram_bus.ram_write_en), 64'd0);
        end
        push    = 1'b0;
        pop     = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_empty", 64'(empty), 64'd1);
            checkOutput("idle_count", 64'(count), 64'd0);
            checkOutput("idle_pop_data", 64'(pop_data), 64'd0);
        end

        // Directed vectors: latency, push+pop on empty, buffer shift with capture.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, vecs[i].pop, 1'b1);
            checkOutput($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].exp_empty));
            checkOutput($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("vec%0d_data", i), 64'(pop_data), 64'(vecs[i].exp_data));
            end
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
        checkOutput("vec_underflow", 64'(underflow), 64'd1);
        checkOutput("vec_overflow", 64'(overflow), 64'd0);
`endif

        // Fill past capacity: 32 RAM words plus 2 buffered, the rest dropped.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, DW'(i), 1'b0, i < 34);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("fill_full", 64'(full), 64'd1);
        checkOutput("fill_count", 64'(count), 64'd34);
        checkOutput("fill_model", 64'(count), 64'(sb.size()));
        push = 1'b1;
        #1;
        checkOutput("fill_write_en_blocked", 64'(ram_bus.ram_write_en), 64'd0);
        push = 1'b0;
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
        checkOutput("fill_overflow", 64'(overflow), 64'd1);
`endif
        drainAll("fill_drain");

        // Streaming: prime three words, then push and pop every cycle across several wraps.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h1000 + DW'(i), 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            checkOutput("stream_not_empty", 64'(empty), 64'd0);
            applyStimulus(1'b1, 32'h2000 + DW'(i), 1'b1, 1'b1);
            checkOutput("stream_count", 64'(count), 64'(sb.size()));
        end
        drainAll("stream_drain");

        // Random traffic, kept below RAM capacity so every push is accepted.
        for (int i = 0; i < 10000; i++) begin
            logic p, q;
            p = 1'($urandom_range(0, 1)) && (sb.size() < 30);
            q = 1'($urandom_range(0, 1));
            applyStimulus(p, $urandom, q, 1'b1);
            if (count != (AW+2)'(sb.size())) checkOutput("rand_count", 64'(count), 64'(sb.size()));
            else checks++;
        end
        drainAll("rand_drain");

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h5000 + DW'(i), 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_empty", 64'(empty), 64'd1);
        checkOutput("async_rst_count", 64'(count), 64'd0);
        checkOutput("async_rst_full", 64'(full), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Flush with ten words held and a read in flight.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h7000 + DW'(i), 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h70AA, 1'b1, 1'b1);
        checkOutput("pre_flush_count", 64'(count), 64'd10);
        sync_reset = 1'b1;
        push       = 1'b1;
        push_data  = 32'hDEAD_BEEF;
        pop        = 1'b1;
        @(posedge clk);
        #1;
        sync_reset = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        sb.delete();
        checkOutput("flush_empty", 64'(empty), 64'd1);
        checkOutput("flush_count", 64'(count), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_flush_empty", 64'(empty), 64'd1);
            checkOutput("post_flush_count", 64'(count), 64'd0);
        end
`ifdef FIFO_RAM_CTRL_ERR_FLAG_EN
        checkOutput("flush_overflow", 64'(overflow), 64'd0);
        checkOutput("flush_underflow", 64'(underflow), 64'd0);
`endif
        applyStimulus(1'b1, 32'h1234, 1'b0, 1'b1);
        for (int k = 0; k < 10 && empty; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("flush_refill_ready", 64'(empty), 64'd0);
        checkOutput("flush_refill_data", 64'(pop_data), 64'h1234);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("flush_final_empty", 64'(empty), 64'd1);
        checkOutput("flush_final_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
